// File: rtl/mdu_sequencer.sv
// Multi-cycle RV32M/RV64M multiply/divide unit for the EX stage: shift-add multiplier,
// restoring divider, stall to the hazard unit while busy, registered result with a done pulse.
module mdu_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic            flush,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            is_mext,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          op;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     rem, quo;
  logic                neg_res, neg_rem;

  assign is_mext   = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
  assign stall     = start && is_mext && !done && !flush;
  assign dbg_state = state;

  // Operand signedness: mul (000) uses the unsigned path since the low word is sign-agnostic.
  logic            a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] a_mag_in, b_mag_in;
  assign a_signed = (Funct3 == 3'b001) || (Funct3 == 3'b010) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
  assign b_signed = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
  assign sa       = a_signed && src_a[XLEN-1];
  assign sb       = b_signed && src_b[XLEN-1];
  assign a_mag_in = sa ? (~src_a + 1'b1) : src_a;
  assign b_mag_in = sb ? (~src_b + 1'b1) : src_b;

  // Multiplier step: add multiplicand into the upper half when the product LSB is set, then shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_step, prod_fix;
  assign mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a_mag} : '0);
  assign prod_step = {mul_sum, prod[XLEN-1:1]};
  assign prod_fix  = neg_res ? (~prod_step + 1'b1) : prod_step;

  // Restoring divider step: dividend bits stream out of quo's MSB into the partial remainder.
  logic [XLEN:0]   div_shift, div_sub;
  logic            div_ge;
  logic [XLEN-1:0] rem_step, quo_step, quo_fix, rem_fix;
  assign div_shift = {rem, quo[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, b_mag};
  assign div_sub   = div_shift - {1'b0, b_mag};
  assign rem_step  = div_ge ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0];
  assign quo_step  = {quo[XLEN-2:0], div_ge};
  assign quo_fix   = neg_res ? (~quo_step + 1'b1) : quo_step;
  assign rem_fix   = neg_rem ? (~rem_step + 1'b1) : rem_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= '0;
      a_mag   <= '0;
      b_mag   <= '0;
      prod    <= '0;
      rem     <= '0;
      quo     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && is_mext) begin
            op      <= Funct3;
            cnt     <= CNT_W'(XLEN-1);
            a_mag   <= a_mag_in;
            b_mag   <= b_mag_in;
            neg_res <= sa ^ sb;
            neg_rem <= sa;
            if (!Funct3[2]) begin
              prod  <= {{XLEN{1'b0}}, b_mag_in};
              state <= MUL;
              busy  <= 1'b1;
            end else if (src_b == '0) begin
              result <= Funct3[1] ? src_a : '1;
              state  <= DONE;
              done   <= 1'b1;
            end else if (!Funct3[0] && (src_a == MOST_NEG) && (src_b == '1)) begin
              result <= Funct3[1] ? '0 : src_a;
              state  <= DONE;
              done   <= 1'b1;
            end else begin
              rem   <= '0;
              quo   <= a_mag_in;
              state <= DIV;
              busy  <= 1'b1;
            end
          end
        end
        MUL: begin
          prod <= prod_step;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            result <= (op[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        DIV: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            result <= op[1] ? rem_fix : quo_fix;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: begin
          // DONE: start still belongs to the finished instruction, so it is not sampled here.
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer (XLEN=32): arithmetic results, latency, stall span,
// special-case divides, flush, back-to-back issue and asynchronous reset.
module tb_mdu_sequencer;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      ALUOp = 2'b00;
  logic [6:0]      Funct7 = 7'b0;
  logic [2:0]      Funct3 = 3'b0;
  logic            flush = 1'b0;
  logic [XLEN-1:0] src_a = '0;
  logic [XLEN-1:0] src_b = '0;
  logic            is_mext, stall, busy, done;
  logic [XLEN-1:0] result;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;

  mdu_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALUOp(ALUOp), .Funct7(Funct7),
    .Funct3(Funct3), .flush(flush), .src_a(src_a), .src_b(src_b),
    .is_mext(is_mext), .stall(stall), .busy(busy), .done(done),
    .result(result), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns cycles from the next posedge until done is seen.
  task automatic wait_done(input int limit, input bit scramble, output int lat, output int stalls);
    lat = 0;
    stalls = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (scramble) begin
        src_a  = 32'hDEADBEEF;
        src_b  = 32'h12345678;
        Funct3 = 3'b101;
      end
      if (!done && stall) stalls++;
    end while (!done && lat < limit);
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL timeout: observed no done after %0d cycles expected done", lat);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp,
                        input int exp_lat, input bit scramble);
    int lat, stalls;
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3; src_a = a; src_b = b; start = 1'b1;
    #1 chk({tag, "_stall_accept"}, stall, 1);
    wait_done(100, scramble, lat, stalls);
    start = 1'b0;
    chk({tag, "_result"}, result, exp);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_stall_cycles"}, stalls, exp_lat - 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int lat, stalls, dones;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Non-M instruction is not accepted.
    ALUOp = 2'b10; Funct7 = 7'b0000000; Funct3 = 3'b000; start = 1'b1;
    #1 chk("nonm_is_mext", is_mext, 0);
    chk("nonm_stall", stall, 0);
    @(negedge clk);
    chk("nonm_busy", busy, 0);
    start = 1'b0;

    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b1);
    run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 1'b0);
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b0);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b0);
    run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33, 1'b0);
    run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33, 1'b0);
    run_op("divu0",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b0);
    run_op("remu0",  3'b111, 32'd5,        32'd0,        32'd5,        1,  1'b0);
    run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b0);
    run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  1'b0);
    run_op("mulneg", 3'b000, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 33, 1'b0);

    // Flush ten cycles into a divide: no done, result keeps the previous value (0xFFFFFFFA).
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b101; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    repeat (10) @(negedge clk);
    chk("flush_busy_before", busy, 1);
    flush = 1'b1;
    #1 chk("flush_stall", stall, 0);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_result", result, 32'hFFFFFFFA);
    chk("flush_state", dbg_state, 0);
    run_op("mul_after_flush", 3'b000, 32'd12345, 32'd1000, 32'd12345000, 33, 1'b0);

    // Back-to-back with start held: divu accepted in the IDLE cycle after the done pulse.
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b000; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
    wait_done(100, 1'b0, lat, stalls);
    chk("b2b_mul_result", result, 15);
    chk("b2b_mul_latency", lat, 33);
    Funct3 = 3'b101; src_a = 32'd100; src_b = 32'd7;
    #1 chk("b2b_done_stall", stall, 0);
    @(negedge clk);
    chk("b2b_idle_state", dbg_state, 0);
    chk("b2b_idle_stall", stall, 1);
    chk("b2b_idle_done", done, 0);
    wait_done(100, 1'b0, lat, stalls);
    start = 1'b0;
    chk("b2b_divu_result", result, 14);
    chk("b2b_divu_latency", lat, 33);
    @(negedge clk);

    // Asynchronous reset in the middle of a multiply.
    Funct3 = 3'b000; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_mid_busy_before", busy, 1);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_result", result, 0);
    chk("rst_mid_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("rst_mid_no_done", dones, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
Parametrised successor to the single-cycle ALU controller. It decodes RV32M/RV64M multiply/divide instructions from ALUOp/Funct7/Funct3 and executes them over multiple cycles with an iterative shift-add multiplier and a restoring divider. It sits in the EX stage beside the ALU. It raises a stall to the hazard unit while busy and returns a registered result with a one-cycle done pulse.

Parameters:
XLEN, 32, operand and result width (32 or 64)
CNT_W, $clog2(XLEN), iteration counter width (derived, not to be overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  EX-stage instruction valid; held high by the pipeline while stalled
ALUOp  in  2  controller op class; 2'b10 = R/I-type
Funct7  in  7  instruction bits 31:25
Funct3  in  3  instruction bits 14:12
flush  in  1  synchronous abort (branch mispredict or trap)
src_a  in  XLEN  rs1 operand
src_b  in  XLEN  rs2 operand
is_mext  out  1  combinational: ALUOp==2'b10 && Funct7==7'b0000001
stall  out  1  combinational: start && is_mext && !done && !flush
busy  out  1  registered: state is MUL or DIV
done  out  1  registered one-cycle pulse: result valid
result  out  XLEN  registered result; held until the next accepted start

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, counter=0, busy=0, done=0, result=0, all internal accumulators=0.
- Funct3 decode: 000 mul (low word), 001 mulh (s×s, high word), 010 mulhsu (s×u, high word), 011 mulhu (u×u, high word), 100 div, 101 divu, 110 rem, 111 remu.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - Accepts when start && is_mext && !flush. Latches operand magnitudes, result-sign flags and Funct3; loads counter=XLEN-1.
  - Funct3[2]=0 goes to MUL.
  - Funct3[2]=1 with divisor==0 goes to DONE. Quotient=all ones; remainder=dividend.
  - Signed div/rem with dividend==most-negative and divisor==all ones goes to DONE. Quotient=dividend; remainder=0.
  - Otherwise goes to DIV.
  - Non-M instruction, or start low: stays in IDLE; stall stays 0.
- MUL: one shift-add step per cycle on a 2*XLEN product. Counter decrements; at counter==0 goes to DONE.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). Counter decrements; at counter==0 goes to DONE.
- Sign fixup on DONE entry:
  - MUL: negate the 2*XLEN product when the operand signs differ (signed variants only).
  - div: negate the quotient when the signs differ.
  - rem: the remainder takes the dividend's sign.
- DONE:
  - done=1 and result is valid.
  - start is ignored in this cycle, because it still belongs to the finished instruction.
  - Always goes to IDLE next cycle.
  - A back-to-back M instruction is accepted in the following IDLE cycle.
- Latency, start accepted at edge 0:
  - Normal mul/div: done high in cycle XLEN+1 (33 for XLEN=32).
  - Special-case div: done high in cycle 1.
- stall is high from the accept cycle through the cycle before done; it is low in the done cycle so the pipeline advances.
- Changes on src_a, src_b or Funct3 while busy are ignored, because the operands are latched.
- flush in any state: next state=IDLE, busy=0, done=0, result unchanged. flush in the accept cycle cancels the accept.
- Reset asserted mid-operation: immediate return to the reset values; no done pulse.
- Arithmetic is modulo 2^XLEN. The high-word ops return bits [2*XLEN-1:XLEN] of the fixed-up product.

Test Plan:
- XLEN=32, mul 7 × 0xFFFFFFFD -> result 0xFFFFFFEB; done exactly 33 cycles after accept; stall high for 32 cycles.
- mulh 0x80000000 × 0x80000000 -> 0x40000000; mulhu 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; mulhsu 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- div 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; rem same operands -> 0xFFFFFFFF; divu 100 / 7 -> 14; remu -> 2.
- divu 5 / 0 -> 0xFFFFFFFF and remu 5 / 0 -> 5, done 1 cycle after accept; div 0x80000000 / 0xFFFFFFFF -> 0x80000000, rem -> 0, 1 cycle.
- flush at cycle 10 of a div -> busy 0 next cycle, no done pulse, result unchanged. A new mul accepted the following cycle completes correctly.
- Back-to-back mul then divu with start held high: second op accepted in the IDLE cycle after the done pulse. Assert rst_n low mid-MUL: outputs zero immediately.
